// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, fixed-latency memory between the instruction-fetch
// port (IF) and the data-memory port (DM) of the core. Each access runs the
// sequence IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Requests are sampled only
// in IDLE. A data request wins a tie. The per-port stall outputs hold the
// requesting pipeline stage until its valid pulse.
//
// Parameters
//   DATA_W      memory word width
//   ADDR_W      word address width
//   MEM_LAT     read latency after the mem_en cycle (1..8)
//   STARVE_MAX  data grants tolerated while a fetch waits (guard build only)
//
// Optional feature: define ARB_STARVE_GUARD_EN to enable the fetch
// starvation guard. Without it, data strictly outranks fetch.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   if_req/if_addr      fetch request, held until if_valid
//   if_rdata/if_valid   registered fetched word and one-cycle completion pulse
//   if_stall            if_req & ~if_valid
//   dm_req/dm_we/dm_addr/dm_wdata   data request, held until dm_valid
//   dm_rdata/dm_valid   registered load data and completion pulse
//   dm_stall            dm_req & ~dm_valid
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory access strobe
//   mem_rdata           read data, valid MEM_LAT cycles after the mem_en cycle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    // instruction-fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    // data-memory port
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    // memory macro side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Parameter sanity: the wait counter is 4 bits, the starve counter 3 bits.
    if (MEM_LAT < 1 || MEM_LAT > 8 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LAT must be 1..8 and STARVE_MAX 1..7");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // WAIT lasts MEM_LAT cycles; the counter is loaded with MEM_LAT-1 on the
    // way out of ISSUE so that it reads zero in the cycle mem_rdata is valid.
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_e              state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic                acc_we_q,    acc_we_d;
    logic [3:0]          cnt_q,       cnt_d;
    logic                mem_en_q,    mem_en_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
    logic                if_valid_q,  if_valid_d;
    logic                dm_valid_q,  dm_valid_d;

    logic                grant_dm;
    logic                grant_if;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic [2:0]          starve_q,    starve_d;
    logic                starved;

    // A waiting fetch that has already watched STARVE_MAX data grants go by
    // takes the next slot even against a pending data request.
    assign starved  = if_req && (starve_q == STARVE_LIM);
    assign grant_dm = dm_req && !starved;
`else
    assign grant_dm = dm_req;
`endif
    assign grant_if = if_req && !grant_dm;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        acc_we_d    = acc_we_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        starve_d    = starve_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // The winner's request is latched here; later changes on the
                // request inputs have no effect on the access in flight.
                if (grant_dm) begin
                    state_d     = ST_ISSUE;
                    owner_d     = OWN_DM;
                    acc_we_d    = dm_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (grant_if) begin
                    state_d     = ST_ISSUE;
                    owner_d     = OWN_IF;
                    acc_we_d    = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
`ifdef ARB_STARVE_GUARD_EN
                // Count data grants only while a fetch is actually waiting.
                if (!if_req || grant_if) begin
                    starve_d = '0;
                end else if (grant_dm) begin
                    starve_d = starve_q + 3'd1;
                end
`endif
            end

            ST_ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_DM) begin
                        dm_valid_d = 1'b1;
                        // A store completes without disturbing the last load.
                        if (!acc_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (reset) begin
            // NOTE: the data registers are reset as well, because both read
            // ports and the memory-side outputs must read zero after reset.
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            acc_we_q    <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            acc_we_q    <= acc_we_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;

    // The stalls drop in the valid cycle itself so the stage advances then.
    assign if_stall  = if_req & ~if_valid_q;
    assign dm_stall  = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. The main instance (MEM_LAT=2) is driven by
// directed scenarios followed by random traffic. A transaction-level model
// predicts every output from the arbitration rules and a timeline counted in
// cycles since the grant. Two more instances check latency at MEM_LAT=1 and
// MEM_LAT=8. Define ARB_STARVE_GUARD_EN for both RTL and bench to exercise
// the starvation guard.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 9;
    localparam int LAT  = 2;
    localparam int SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          dm_stall;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // latency instances (fetch port only)
    logic          l1_req, l8_req;
    logic [DW-1:0] l1_if_rdata, l8_if_rdata, l1_dm_rdata, l8_dm_rdata;
    logic          l1_if_valid, l8_if_valid, l1_if_stall, l8_if_stall;
    logic          l1_dm_valid, l8_dm_valid, l1_dm_stall, l8_dm_stall;
    logic          l1_mem_en, l8_mem_en, l1_mem_we, l8_mem_we;
    logic [AW-1:0] l1_mem_addr, l8_mem_addr;
    logic [DW-1:0] l1_mem_wdata, l8_mem_wdata, l1_mem_rdata, l8_mem_rdata;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_lat1 (
        .clk(clk), .reset(reset),
        .if_req(l1_req), .if_addr(9'h010), .if_rdata(l1_if_rdata),
        .if_valid(l1_if_valid), .if_stall(l1_if_stall),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(9'h000), .dm_wdata(32'h0),
        .dm_rdata(l1_dm_rdata), .dm_valid(l1_dm_valid), .dm_stall(l1_dm_stall),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
    );

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(8), .STARVE_MAX(SMAX)) u_lat8 (
        .clk(clk), .reset(reset),
        .if_req(l8_req), .if_addr(9'h010), .if_rdata(l8_if_rdata),
        .if_valid(l8_if_valid), .if_stall(l8_if_stall),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(9'h000), .dm_wdata(32'h0),
        .dm_rdata(l8_dm_rdata), .dm_valid(l8_dm_valid), .dm_stall(l8_dm_stall),
        .mem_en(l8_mem_en), .mem_we(l8_mem_we), .mem_addr(l8_mem_addr),
        .mem_wdata(l8_mem_wdata), .mem_rdata(l8_mem_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Memory macros: a storage array that answers exactly LAT cycles after
    // mem_en and drives noise on every other cycle.
    // ------------------------------------------------------------------
    logic [DW-1:0] resp_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem  [0:(1<<AW)-1];
    bit            dl_v [0:7];
    logic [DW-1:0] dl_d [0:7];

    initial begin
        mem_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            dl_v[i] = 1'b0;
            dl_d[i] = '0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 7; i++) begin
                dl_v[i] = dl_v[i+1];
                dl_d[i] = dl_d[i+1];
            end
            dl_v[7] = 1'b0;
            if (mem_en === 1'b1) begin
                if (mem_we) begin
                    resp_mem[mem_addr] = mem_wdata;
                end else begin
                    dl_v[LAT-1] = 1'b1;
                    dl_d[LAT-1] = resp_mem[mem_addr];
                end
            end
            #1;
            mem_rdata = dl_v[0] ? dl_d[0] : $urandom;
        end
    end

    // Latency instances: a count of cycles since mem_en picks the answer cycle.
    int l1_cnt = 0;
    int l8_cnt = 0;
    initial begin
        l1_mem_rdata = 32'hBAD0_BAD0;
        l8_mem_rdata = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk);
            if (l1_mem_en === 1'b1) l1_cnt = 1;
            else if (l1_cnt != 0 && l1_cnt < 15) l1_cnt++;
            if (l8_mem_en === 1'b1) l8_cnt = 1;
            else if (l8_cnt != 0 && l8_cnt < 15) l8_cnt++;
            #1;
            l1_mem_rdata = (l1_cnt == 1) ? 32'hC0DE_0001 : 32'hBAD0_BAD0 ^ $urandom;
            l8_mem_rdata = (l8_cnt == 8) ? 32'hC0DE_0008 : 32'hBAD0_BAD0 ^ $urandom;
        end
    end

    // ------------------------------------------------------------------
    // Transaction-level model of the main instance. An access occupies
    // LAT+3 cycles counted from its grant edge: mem_en one cycle later, the
    // result LAT+1 edges later, the valid pulse for one cycle, then free.
    // ------------------------------------------------------------------
    logic          exp_mem_en, exp_mem_we, exp_if_valid, exp_dm_valid;
    logic [AW-1:0] exp_mem_addr;
    logic [DW-1:0] exp_mem_wdata, exp_if_rdata, exp_dm_rdata;
    bit            m_busy = 1'b0;
    bit            m_dm, m_we, m_take_if;
    int            m_k, m_starve;
    logic [DW-1:0] m_rd;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_starve = 0;
            exp_mem_en = 1'b0; exp_mem_we = 1'b0; exp_mem_addr = '0; exp_mem_wdata = '0;
            exp_if_valid = 1'b0; exp_dm_valid = 1'b0; exp_if_rdata = '0; exp_dm_rdata = '0;
        end else begin
            exp_mem_en = 1'b0; exp_mem_we = 1'b0;
            exp_if_valid = 1'b0; exp_dm_valid = 1'b0;
            if (!m_busy) begin
                m_take_if = if_req && (!dm_req || (GUARD && m_starve == SMAX));
                if (m_take_if) begin
                    m_busy = 1'b1; m_k = 0; m_dm = 1'b0; m_we = 1'b0;
                    m_rd = ref_mem[if_addr];
                    exp_mem_en = 1'b1; exp_mem_addr = if_addr; exp_mem_wdata = '0;
                end else if (dm_req) begin
                    m_busy = 1'b1; m_k = 0; m_dm = 1'b1; m_we = dm_we;
                    exp_mem_en = 1'b1; exp_mem_we = dm_we;
                    exp_mem_addr = dm_addr; exp_mem_wdata = dm_wdata;
                    if (dm_we) ref_mem[dm_addr] = dm_wdata;
                    else       m_rd = ref_mem[dm_addr];
                end
                if (!if_req || m_take_if) m_starve = 0;
                else if (dm_req)          m_starve++;
            end else begin
                m_k++;
                if (m_k == LAT + 1) begin
                    if (m_dm) begin
                        exp_dm_valid = 1'b1;
                        if (!m_we) exp_dm_rdata = m_rd;
                    end else begin
                        exp_if_valid = 1'b1;
                        exp_if_rdata = m_rd;
                    end
                end else if (m_k == LAT + 2) begin
                    m_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("mem_en",    mem_en,    exp_mem_en);
            check("mem_we",    mem_we,    exp_mem_we);
            check("mem_addr",  mem_addr,  exp_mem_addr);
            check("mem_wdata", mem_wdata, exp_mem_wdata);
            check("if_valid",  if_valid,  exp_if_valid);
            check("dm_valid",  dm_valid,  exp_dm_valid);
            check("if_rdata",  if_rdata,  exp_if_rdata);
            check("dm_rdata",  dm_rdata,  exp_dm_rdata);
            check("if_stall",  if_stall,  if_req & ~exp_if_valid);
            check("dm_stall",  dm_stall,  dm_req & ~exp_dm_valid);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with hand-computed expectations, then random traffic
    // ------------------------------------------------------------------
    logic [DW-1:0] tmp_word;
    int            dm_cnt, dm_cnt_at_if, if_cyc;
    bit            seen_if, stop_req;

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        l1_req = 1'b0; l8_req = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin
            tmp_word = $urandom;
            ref_mem[i] = tmp_word;
            resp_mem[i] = tmp_word;
        end
        ref_mem[9'h010] = 32'h00A0_0093; resp_mem[9'h010] = 32'h00A0_0093;
        ref_mem[9'h014] = 32'h0000_0013; resp_mem[9'h014] = 32'h0000_0013;
        ref_mem[9'h080] = 32'h1234_5678; resp_mem[9'h080] = 32'h1234_5678;

        tick();
        chk_on = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset_mem_en",   mem_en,    1'b0);
        check("reset_mem_addr", mem_addr,  9'h0);
        check("reset_if_rdata", if_rdata,  32'h0);
        check("reset_dm_valid", dm_valid,  1'b0);
        tick();

        // Lone fetch: mem_en cycle 1, if_valid cycle 4, stall cycles 0-3.
        if_req = 1'b1; if_addr = 9'h010;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            check("t1_stall",    if_stall, (i < 4));
            check("t1_mem_en",   mem_en,   (i == 1));
            check("t1_if_valid", if_valid, (i == 4));
            if (i == 1) check("t1_mem_addr", mem_addr, 9'h010);
            if (i == 4) begin
                check("t1_if_rdata", if_rdata, 32'h00A0_0093);
                check("t1_model_if_rdata", exp_if_rdata, 32'h00A0_0093);
            end
            tick();
            if (i == 4) if_req = 1'b0;
        end

        // Simultaneous requests: data first, fetch mem_en 6, if_valid 9.
        if_req = 1'b1; if_addr = 9'h014;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h080; dm_wdata = 32'h0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            check("t2_mem_en",   mem_en,   (i == 1 || i == 6));
            check("t2_dm_valid", dm_valid, (i == 4));
            check("t2_if_valid", if_valid, (i == 9));
            check("t2_if_stall", if_stall, (i < 9));
            check("t2_dm_stall", dm_stall, (i < 4));
            if (i == 1) check("t2_mem_addr_dm", mem_addr, 9'h080);
            if (i == 6) check("t2_mem_addr_if", mem_addr, 9'h014);
            if (i == 4) begin
                check("t2_dm_rdata", dm_rdata, 32'h1234_5678);
                check("t2_model_dm_valid", exp_dm_valid, 1'b1);
            end
            if (i == 9) check("t2_if_rdata", if_rdata, 32'h0000_0013);
            tick();
            if (i == 4) dm_req = 1'b0;
            if (i == 9) if_req = 1'b0;
        end

        // Store: one mem_en/mem_we cycle, dm_valid pulse, dm_rdata untouched.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'h044; dm_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            check("t3_mem_en",   mem_en,   (i == 1));
            check("t3_mem_we",   mem_we,   (i == 1));
            check("t3_dm_valid", dm_valid, (i == 4));
            if (i == 1) begin
                check("t3_mem_addr",  mem_addr,  9'h044);
                check("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            end
            if (i >= 4) check("t3_dm_rdata_kept", dm_rdata, 32'h1234_5678);
            tick();
            if (i == 4) begin
                dm_req = 1'b0; dm_we = 1'b0;
            end
        end

        // Reset in cycle 2 of a fetch: zeros in cycle 3, no valid at 4,
        // the still-held request restarts and completes at cycle 7.
        if_req = 1'b1; if_addr = 9'h010;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            check("t4_if_valid", if_valid, (i == 7));
            check("t4_mem_en",   mem_en,   (i == 1 || i == 4));
            if (i == 3) begin
                check("t4_rst_mem_addr",  mem_addr,  9'h0);
                check("t4_rst_mem_wdata", mem_wdata, 32'h0);
                check("t4_rst_mem_we",    mem_we,    1'b0);
                check("t4_rst_if_rdata",  if_rdata,  32'h0);
                check("t4_rst_dm_rdata",  dm_rdata,  32'h0);
                check("t4_rst_dm_valid",  dm_valid,  1'b0);
            end
            if (i == 7) check("t4_if_rdata", if_rdata, 32'h00A0_0093);
            tick();
            if (i == 1) reset = 1'b1;
            if (i == 2) reset = 1'b0;
            if (i == 7) if_req = 1'b0;
        end
        tick();

        // Starvation: data held continuously while a fetch waits.
        if_req = 1'b1; if_addr = 9'h010;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h080;
        dm_cnt = 0; dm_cnt_at_if = -1; if_cyc = -1; seen_if = 1'b0; stop_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dm_valid === 1'b1) dm_cnt++;
            if (if_valid === 1'b1 && !seen_if) begin
                seen_if = 1'b1;
                dm_cnt_at_if = dm_cnt;
                if_cyc = i;
                stop_req = 1'b1;
            end
            tick();
            if (stop_req) begin
                if_req = 1'b0; dm_req = 1'b0;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        if (GUARD) begin
            check("t5_fetch_granted",      seen_if,      1'b1);
            check("t5_data_grants_before", dm_cnt_at_if, SMAX);
            check("t5_if_valid_cycle",     if_cyc,       24);
        end else begin
            check("t5_fetch_not_granted",  seen_if,      1'b0);
            check("t5_data_grants",        dm_cnt,       8);
        end
        repeat (8) tick();

        // Latency extremes: valid at cycle 3 (MEM_LAT=1) and 10 (MEM_LAT=8).
        l1_req = 1'b1; l8_req = 1'b1;
        for (int i = 0; i <= 11; i++) begin
            @(negedge clk);
            check("t6_l1_if_valid", l1_if_valid, (i == 3));
            check("t6_l8_if_valid", l8_if_valid, (i == 10));
            check("t6_l1_mem_en",   l1_mem_en,   (i == 1));
            check("t6_l8_mem_en",   l8_mem_en,   (i == 1));
            check("t6_l1_stall",    l1_if_stall, (i < 3));
            check("t6_l8_stall",    l8_if_stall, (i < 10));
            if (i == 1) begin
                check("t6_l1_mem_addr", l1_mem_addr, 9'h010);
                check("t6_l8_mem_addr", l8_mem_addr, 9'h010);
            end
            if (i == 3)  check("t6_l1_if_rdata", l1_if_rdata, 32'hC0DE_0001);
            if (i == 10) check("t6_l8_if_rdata", l8_if_rdata, 32'hC0DE_0008);
            tick();
            if (i == 3)  l1_req = 1'b0;
            if (i == 10) l8_req = 1'b0;
        end

        // Random traffic, including withdrawn requests and rare resets.
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            if_req   = ($urandom_range(0, 9) < 6);
            dm_req   = ($urandom_range(0, 9) < 4);
            dm_we    = 1'($urandom_range(0, 1));
            if_addr  = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
            dm_addr  = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
            dm_wdata = $urandom;
            tick();
        end
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        repeat (15) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
